raster_window_scanner: RTL and testbench

Parametrised raster-scan pixel/address generator for the framebuffer draw path. On a start command it walks either the whole screen or a clipped rectangular window in row-major order, presenting X, Y and linear framebuffer address for each pixel. The downstream plotter consumes pixels through a valid/enable handshake. It sits between the game-logic draw FSM (clear screen, draw snake segment, draw food tile) and the VGA adapter / framebuffer write port.

---
 rtl/raster_window_scanner.sv | 153 +++++++++++++++
 tb/tb_raster_window_scanner.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/raster_window_scanner.sv
// Raster-scan pixel/address generator for the framebuffer draw path.
// Walks the full screen or a clipped window in row-major order.
module raster_window_scanner #(
  parameter int SCREEN_W  = 160,
  parameter int SCREEN_H  = 120,
  parameter int X_BITS    = 8,
  parameter int Y_BITS    = 7,
  parameter int ADDR_BITS = 15
) (
  input  logic                 iClock,
  input  logic                 iReset,
  input  logic                 iStart,
  input  logic                 iMode,
  input  logic [X_BITS-1:0]    iX0,
  input  logic [Y_BITS-1:0]    iY0,
  input  logic [X_BITS-1:0]    iW,
  input  logic [Y_BITS-1:0]    iH,
  input  logic                 iEnable,
  input  logic                 iAbort,
  output logic [X_BITS-1:0]    oX,
  output logic [Y_BITS-1:0]    oY,
  output logic [ADDR_BITS-1:0] oAddress,
  output logic                 oValid,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam int XW = X_BITS + 1;
  localparam int YW = Y_BITS + 1;

  localparam logic [XW-1:0]        SW_X = XW'(SCREEN_W);
  localparam logic [YW-1:0]        SH_Y = YW'(SCREEN_H);
  localparam logic [ADDR_BITS-1:0] SW_A = ADDR_BITS'(SCREEN_W);

  typedef enum logic {
    IDLE,
    SCAN
  } state_t;

  state_t state;

  logic [X_BITS-1:0]    x0_q;
  logic [Y_BITS-1:0]    y0_q;
  logic [X_BITS-1:0]    x_last_q;
  logic [Y_BITS-1:0]    y_last_q;
  logic [ADDR_BITS-1:0] row_step_q;

  logic [X_BITS-1:0]    x0_eff;
  logic [Y_BITS-1:0]    y0_eff;
  logic [XW-1:0]        x_room;
  logic [YW-1:0]        y_room;
  logic [XW-1:0]        w_eff;
  logic [YW-1:0]        h_eff;
  logic                 empty;
  logic [X_BITS-1:0]    x_last;
  logic [Y_BITS-1:0]    y_last;
  logic [ADDR_BITS-1:0] row_step;
  logic [ADDR_BITS-1:0] start_addr;

  // Geometry is computed one bit wide so clipping never wraps.
  always_comb begin
    x0_eff = '0;
    y0_eff = '0;
    x_room = SW_X;
    y_room = SH_Y;
    w_eff  = SW_X;
    h_eff  = SH_Y;
    if (iMode) begin
      x0_eff = iX0;
      y0_eff = iY0;
      x_room = ({1'b0, iX0} >= SW_X) ? '0 : SW_X - {1'b0, iX0};
      y_room = ({1'b0, iY0} >= SH_Y) ? '0 : SH_Y - {1'b0, iY0};
      w_eff  = ({1'b0, iW} < x_room) ? {1'b0, iW} : x_room;
      h_eff  = ({1'b0, iH} < y_room) ? {1'b0, iH} : y_room;
    end
  end

  assign empty  = (w_eff == '0) || (h_eff == '0);
  assign x_last = x0_eff + w_eff[X_BITS-1:0] - X_BITS'(1);
  assign y_last = y0_eff + h_eff[Y_BITS-1:0] - Y_BITS'(1);

  assign row_step = SW_A - ADDR_BITS'(w_eff)
                  + ADDR_BITS'(1);

  // One multiply per start only; the scan loop is purely incremental.
  assign start_addr = ADDR_BITS'(y0_eff) * SW_A
                    + ADDR_BITS'(x0_eff);

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state      <= IDLE;
      x0_q       <= '0;
      y0_q       <= '0;
      x_last_q   <= '0;
      y_last_q   <= '0;
      row_step_q <= '0;
      oX         <= '0;
      oY         <= '0;
      oAddress   <= '0;
      oValid     <= 1'b0;
      oBusy      <= 1'b0;
      oDone      <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          oDone <= 1'b0;
          if (iStart) begin
            if (empty) begin
              oDone <= 1'b1;
            end else begin
              state      <= SCAN;
              x0_q       <= x0_eff;
              y0_q       <= y0_eff;
              x_last_q   <= x_last;
              y_last_q   <= y_last;
              row_step_q <= row_step;
              oX         <= x0_eff;
              oY         <= y0_eff;
              oAddress   <= start_addr;
              oValid     <= 1'b1;
              oBusy      <= 1'b1;
            end
          end
        end
        SCAN: begin
          if (iAbort) begin
            state  <= IDLE;
            oValid <= 1'b0;
            oBusy  <= 1'b0;
          end else if (iEnable) begin
            if (oX == x_last_q) begin
              if (oY == y_last_q) begin
                state  <= IDLE;
                oValid <= 1'b0;
                oBusy  <= 1'b0;
                oDone  <= 1'b1;
              end else begin
                oX       <= x0_q;
                oY       <= oY + Y_BITS'(1);
                oAddress <= oAddress + row_step_q;
              end
            end else begin
              oX       <= oX + X_BITS'(1);
              oAddress <= oAddress + ADDR_BITS'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_raster_window_scanner.sv
// Directed bench for raster_window_scanner.
// Hand-picked geometries with an expected-pixel walker.
module tb_raster_window_scanner;

  logic        clk = 1'b0;
  logic        iReset, iStart, iMode, iEnable, iAbort;
  logic [7:0]  iX0, iW;
  logic [6:0]  iY0, iH;
  logic [7:0]  oX;
  logic [6:0]  oY;
  logic [14:0] oAddress;
  logic        oValid, oBusy, oDone;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  raster_window_scanner dut (
    .iClock  (clk),
    .iReset  (iReset),
    .iStart  (iStart),
    .iMode   (iMode),
    .iX0     (iX0),
    .iY0     (iY0),
    .iW      (iW),
    .iH      (iH),
    .iEnable (iEnable),
    .iAbort  (iAbort),
    .oX      (oX),
    .oY      (oY),
    .oAddress(oAddress),
    .oValid  (oValid),
    .oBusy   (oBusy),
    .oDone   (oDone)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pix(input int x, input int y);
    return {2'b0, 8'(x), 7'(y), 15'(y * 160 + x)};
  endfunction

  // Walks the expected window; enable asserted on cycles where cyc%per==0.
  task automatic scan_check(input string tag, input int x0, input int y0,
                            input int w, input int h, input int per,
                            input bit poke);
    int ex = x0;
    int ey = y0;
    int acc = 0;
    int cyc = 0;
    int bad = 0;
    while (oValid && cyc < 40000) begin
      iEnable = (cyc % per) == 0;
      iStart  = poke && (cyc == 2);
      if (poke && cyc == 2) begin
        iMode = 1'b0;
        iX0   = 8'd0;
        iW    = 8'd1;
      end
      if ({2'b0, oX, oY, oAddress} !== pix(ex, ey) || !oBusy) begin
        if (bad == 0) chk({tag, "_pix"}, {2'b0, oX, oY, oAddress}, pix(ex, ey));
        bad++;
      end
      tick();
      iStart = 1'b0;
      if (iEnable) begin
        acc++;
        ex++;
        if (ex == x0 + w) begin
          ex = x0;
          ey++;
        end
      end
      cyc++;
    end
    chk({tag, "_bad"}, bad, 0);
    chk({tag, "_count"}, acc, w * h);
    chk({tag, "_done"}, {oDone, oBusy, oValid}, 3'b100);
    chk({tag, "_hold"}, {2'b0, oX, oY, oAddress},
        pix(x0 + w - 1, y0 + h - 1));
    iEnable = 1'b1;
  endtask

  initial begin
    iReset = 1'b1; iStart = 1'b0; iMode = 1'b0; iEnable = 1'b1;
    iAbort = 1'b0; iX0 = '0; iY0 = '0; iW = '0; iH = '0;
    tick(); tick();
    iReset = 1'b0;
    chk("reset", {oX, oY, oAddress, oValid, oBusy, oDone}, '0);

    // Full screen
    iMode = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("full_first", {2'b0, oX, oY, oAddress}, pix(0, 0));
    scan_check("full", 0, 0, 160, 120, 1, 1'b0);
    chk("full_last_addr", 32'(oAddress), 32'd19199);

    // Clipped window started in the done cycle: 150,10 20x2 -> 10x2
    iMode = 1'b1; iX0 = 8'd150; iY0 = 7'd10; iW = 8'd20; iH = 7'd2;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("clip_first_addr", 32'(oAddress), 32'd1750);
    scan_check("clip", 150, 10, 10, 2, 1, 1'b0);
    chk("clip_last_addr", 32'(oAddress), 32'd1919);

    // 4x3 at (5,5), stalls, start poked mid-scan
    iMode = 1'b1; iX0 = 8'd5; iY0 = 7'd5; iW = 8'd4; iH = 7'd3;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("stall_first_addr", 32'(oAddress), 32'd805);
    scan_check("stall", 5, 5, 4, 3, 3, 1'b1);
    chk("stall_last_addr", 32'(oAddress), 32'd1128);
    tick();
    chk("done_pulse_end", {oDone, oValid}, 2'b00);

    // Empty regions
    iMode = 1'b1; iX0 = 8'd0; iY0 = 7'd0; iW = 8'd0; iH = 7'd5;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("empty_w0", {oDone, oBusy, oValid}, 3'b100);
    tick();
    chk("empty_w0_end", {oDone, oBusy, oValid}, 3'b000);
    iX0 = 8'd160; iW = 8'd4;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("empty_x160", {oDone, oBusy, oValid}, 3'b100);
    tick();
    iX0 = 8'd0; iY0 = 7'd120; iH = 7'd3;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("empty_y120", {oDone, oBusy, oValid}, 3'b100);
    tick();

    // Abort at pixel 500, then immediate window start
    iMode = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 500; i++) tick();
    chk("abort_pix500", {2'b0, oX, oY, oAddress}, pix(20, 3));
    iAbort = 1'b1;
    tick();
    iAbort = 1'b0;
    chk("abort", {oDone, oBusy, oValid}, 3'b000);
    iMode = 1'b1; iX0 = 8'd2; iY0 = 7'd3; iW = 8'd3; iH = 7'd2;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("after_abort_first", {2'b0, oX, oY, oAddress}, pix(2, 3));
    scan_check("after_abort", 2, 3, 3, 2, 1, 1'b0);

    // Reset mid-scan
    iMode = 1'b0; iStart = 1'b1;
    tick();
    iStart = 1'b0;
    for (int i = 0; i < 50; i++) tick();
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    chk("midreset", {oX, oY, oAddress, oValid, oBusy, oDone}, '0);
    tick();
    chk("midreset_idle", {oDone, oBusy, oValid}, 3'b000);
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    chk("restart_first", {2'b0, oX, oY, oAddress, oValid}, {pix(0, 0), 1'b1});
    tick();
    chk("restart_second", {2'b0, oX, oY, oAddress}, pix(1, 0));

    $display("== %0d vectors applied, %0d miscompares ==", vectors,
             miscompares);
    $finish;
  end

endmodule
